// File: rtl/crc32_sig_frame_chk_pkg.sv
// Shared CRC32 definitions for the frame checker: polynomial, 64-bit zero-advance
// matrix (MSB-first bit order, same as the signature core) and FSM/control types.
package crc32_sig_frame_chk_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_e;

    typedef struct packed {
        logic v;
        logic s;
        logic e;
    } ctrl_t;

    // Shift 64 zero bits through the CRC register; unrolls to a pure XOR matrix.
    function automatic logic [31:0] crc32_adv64(input logic [31:0] crc);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 64; i++) begin
            c = {c[30:0], 1'b0} ^ (c[31] ? CRC32_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_sig_frame_chk_sig_ctrl_dly.sv
// SIG_LAT-deep delay line for {valid,sop,eop} so control lines up with the
// signature core output.
module crc32_sig_frame_chk_sig_ctrl_dly
    import crc32_sig_frame_chk_pkg::*;
#(
    parameter int SIG_LAT = 2
) (
    input  logic  clk_i,
    input  logic  arst_i,
    input  ctrl_t d_i,
    output ctrl_t q_o
);

    ctrl_t stage_q [SIG_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < SIG_LAT; gi++) begin : g_stage
            ctrl_t src;
            if (gi == 0) begin : g_first
                assign src = d_i;
            end else begin : g_rest
                assign src = stage_q[gi-1];
            end
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= src;
                end
            end
        end
    endgenerate

    assign q_o = stage_q[SIG_LAT-1];

endmodule

// File: rtl/crc32_sig_frame_chk.sv
// Folds per-word CRC32 signatures into a running frame CRC and reports
// final CRC, word count and residue check at end of frame.
module crc32_sig_frame_chk
    import crc32_sig_frame_chk_pkg::*;
#(
    parameter int          SIG_LAT  = 2,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE  = 32'hC704DD7B,
    parameter int          LEN_W    = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [31:0]      sig_in,
    output logic             res_valid,
    output logic [31:0]      res_crc,
    output logic             res_ok,
    output logic [LEN_W-1:0] res_len,
    output logic             err_sop,
    output logic             err_orph
);

    ctrl_t ctrl_in;
    ctrl_t dly;

    assign ctrl_in = '{v: in_valid, s: in_sop, e: in_eop};

    crc32_sig_frame_chk_sig_ctrl_dly #(
        .SIG_LAT(SIG_LAT)
    ) u_dly (
        .clk_i (clk),
        .arst_i(arst),
        .d_i   (ctrl_in),
        .q_o   (dly)
    );

    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_crc_q, res_crc_d;
    logic             res_ok_q, res_ok_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic             err_sop_q, err_sop_d;
    logic             err_orph_q, err_orph_d;

    logic [31:0]      start_acc;
    logic [31:0]      cont_acc;
    logic [LEN_W-1:0] cnt_inc;
    logic             take;

    // ADV(CRC_INIT) is constant and folds away; only ADV(acc_q) costs logic.
    assign start_acc = crc32_adv64(CRC_INIT) ^ sig_in;
    assign cont_acc  = crc32_adv64(acc_q) ^ sig_in;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
    assign take      = dly.v && (dly.s || (state_q == IN_FRAME));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_crc_d   = res_crc_q;
        res_ok_d    = res_ok_q;
        res_len_d   = res_len_q;
        err_sop_d   = 1'b0;
        err_orph_d  = 1'b0;

        err_sop_d  = dly.v && dly.s && (state_q == IN_FRAME);
        err_orph_d = dly.v && !dly.s && (state_q == IDLE);

        if (take) begin
            acc_d = dly.s ? start_acc : cont_acc;
            cnt_d = dly.s ? LEN_W'(1) : cnt_inc;
            if (dly.e) begin
                state_d     = IDLE;
                res_valid_d = 1'b1;
                res_crc_d   = acc_d;
                res_ok_d    = (acc_d == RESIDUE);
                res_len_d   = cnt_d;
            end else begin
                state_d = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_ok_q    <= 1'b0;
            res_len_q   <= '0;
            err_sop_q   <= 1'b0;
            err_orph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_ok_q    <= res_ok_d;
            res_len_q   <= res_len_d;
            err_sop_q   <= err_sop_d;
            err_orph_q  <= err_orph_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_ok    = res_ok_q;
    assign res_len   = res_len_q;
    assign err_sop   = err_sop_q;
    assign err_orph  = err_orph_q;

endmodule

// File: tb/tb_crc32_sig_frame_chk.sv
// Scoreboard bench for crc32_sig_frame_chk: directed frames then random traffic,
// expected events from a frame-level model using polynomial-division ADV.
module tb_crc32_sig_frame_chk;

    localparam int          L      = 2;
    localparam int          LEN_W  = 3;
    localparam logic [31:0] INIT   = 32'h0;
    localparam logic [31:0] RES    = 32'h0;
    localparam int          MAXLEN = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             arst;
    logic             in_valid, in_sop, in_eop;
    logic [31:0]      sig_in;
    logic             res_valid, res_ok, err_sop, err_orph;
    logic [31:0]      res_crc;
    logic [LEN_W-1:0] res_len;

    crc32_sig_frame_chk #(
        .SIG_LAT (L),
        .CRC_INIT(INIT),
        .RESIDUE (RES),
        .LEN_W   (LEN_W)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .sig_in   (sig_in),
        .res_valid(res_valid),
        .res_crc  (res_crc),
        .res_ok   (res_ok),
        .res_len  (res_len),
        .err_sop  (err_sop),
        .err_orph (err_orph)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] crc;
        int          len;
        bit          ok;
    } res_t;

    res_t        res_q [$];
    int          sop_q [$];
    int          orph_q[$];
    logic [31:0] hist  [L];
    bit          in_fr;
    bit          zero_frame;
    logic [31:0] m_acc;
    int          m_cnt;
    bit          running = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // a * x^64 mod P by long division of the 96-bit product
    function automatic logic [31:0] ref_adv(input logic [31:0] a);
        logic [95:0] v;
        logic [95:0] p;
        v = {a, 64'h0};
        for (int i = 95; i >= 32; i--) begin
            if (v[i]) begin
                p = {63'h0, 33'h1_04C11DB7} << (i - 32);
                v = v ^ p;
            end
        end
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model(input bit v, input bit s, input bit e, input logic [31:0] sig);
        int   t;
        res_t r;
        t = cyc + L + 1;
        if (!v) return;
        if (s) begin
            if (in_fr) sop_q.push_back(t);
            m_acc = ref_adv(INIT) ^ sig;
            m_cnt = 1;
        end else if (!in_fr) begin
            orph_q.push_back(t);
            return;
        end else begin
            m_acc = ref_adv(m_acc) ^ sig;
            if (m_cnt < MAXLEN) m_cnt++;
        end
        if (e) begin
            r.cyc = t; r.crc = m_acc; r.len = m_cnt; r.ok = (m_acc == RES);
            res_q.push_back(r);
            in_fr = 1'b0;
        end else begin
            in_fr = 1'b1;
        end
    endtask

    // sig_in for this cycle belongs to the word issued L cycles ago
    task automatic step(input bit v, input bit s, input bit e, input logic [31:0] sig);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        sig_in   = hist[L-1];
        for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig;
        model(v, s, e, sig);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        arst = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        while (res_q.size() > 0 && res_q[$].cyc >= cyc) void'(res_q.pop_back());
        while (sop_q.size() > 0 && sop_q[$] >= cyc) void'(sop_q.pop_back());
        while (orph_q.size() > 0 && orph_q[$] >= cyc) void'(orph_q.pop_back());
        in_fr = 1'b0;
        for (int i = 0; i < L; i++) hist[i] = '0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_crc",   res_crc,   0);
        chk("rst_res_ok",    res_ok,    0);
        chk("rst_res_len",   res_len,   0);
        chk("rst_err_sop",   err_sop,   0);
        chk("rst_err_orph",  err_orph,  0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        res_t r;
        bit   exp_v;
        if (running && !arst) begin
            exp_v = (res_q.size() > 0) && (res_q[0].cyc == cyc);
            chk("res_valid", res_valid, exp_v);
            if (exp_v) begin
                r = res_q.pop_front();
                $display("result cycle %0d crc %08h len %0d ok %0d", cyc, res_crc, res_len, res_ok);
                if (res_valid) begin
                    chk("res_crc", res_crc, r.crc);
                    chk("res_len", res_len, r.len);
                    chk("res_ok",  res_ok,  r.ok);
                end
            end
            exp_v = (sop_q.size() > 0) && (sop_q[0] == cyc);
            chk("err_sop", err_sop, exp_v);
            if (exp_v) void'(sop_q.pop_front());
            exp_v = (orph_q.size() > 0) && (orph_q[0] == cyc);
            chk("err_orph", err_orph, exp_v);
            if (exp_v) void'(orph_q.pop_front());
        end
    end

    initial begin
        bit v, s, e;
        logic [31:0] sig;
        arst = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; sig_in = '0;
        for (int i = 0; i < L; i++) hist[i] = '0;
        in_fr = 1'b0; zero_frame = 1'b0; m_acc = '0; m_cnt = 0;
        #1;
        chk("init_res_valid", res_valid, 0);
        chk("init_res_crc",   res_crc,   0);
        chk("init_res_len",   res_len,   0);
        chk("init_err_sop",   err_sop,   0);
        chk("init_err_orph",  err_orph,  0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        running = 1'b1;

        // single-word frame
        step(1, 1, 1, 32'h12345678);
        // three words with bubbles
        step(1, 1, 0, 32'hA5A5_0001);
        step(0, 0, 0, 32'hDEAD_BEEF);
        step(0, 0, 0, 32'hCAFE_F00D);
        step(1, 0, 0, 32'h0BAD_F00D);
        step(1, 0, 1, 32'h1357_9BDF);
        // all-zero frame meets residue
        step(1, 1, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h0);
        // sop inside open frame aborts it
        step(1, 1, 0, 32'h1111_2222);
        step(1, 0, 0, 32'h3333_4444);
        step(1, 1, 0, 32'h5555_6666);
        step(1, 0, 1, 32'h7777_8888);
        // orphan word, then back-to-back frames
        step(1, 0, 0, 32'h9999_AAAA);
        step(1, 1, 1, 32'hBBBB_CCCC);
        step(1, 1, 0, 32'hDDDD_EEEE);
        step(1, 0, 1, 32'hFFFF_0000);
        step(1, 1, 1, 32'h0123_4567);
        // reset mid-frame, orphan afterwards, saturating length
        step(1, 1, 0, 32'h89AB_CDEF);
        step(1, 0, 0, 32'h7654_3210);
        do_reset();
        step(1, 0, 1, 32'h2468_ACE0);
        for (int i = 0; i < 10; i++) step(1, (i == 0), (i == 9), $urandom);
        repeat (L + 2) step(0, 0, 0, $urandom);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                s = in_fr ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) != 0);
                e = ($urandom_range(0, 3) == 0);
                if (v && s) zero_frame = ($urandom_range(0, 3) == 0);
                sig = (v && zero_frame) ? 32'h0 : $urandom;
                step(v, s, e, sig);
            end
        end

        repeat (L + 3) step(0, 0, 0, $urandom);
        chk("pending_results", res_q.size(), 0);
        chk("pending_err_sop", sop_q.size(), 0);
        chk("pending_err_orph", orph_q.size(), 0);
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
